// File: rtl/alu_flag_unit.sv
// rtl/alu_flag_unit.sv - flag register and flag-update stage behind the nibble-serial ALU
module alu_flag_unit (
    input  logic       clk,
    input  logic       reset,
    input  logic       alu_l,
    input  logic       alu_h,
    input  logic       nib_zero,
    input  logic       nib_cout,
    input  logic       alu_ne,
    input  logic       c_from_lo,
    input  logic [1:0] z_sel,
    input  logic [1:0] n_sel,
    input  logic [1:0] h_sel,
    input  logic [1:0] c_sel,
    input  logic       f_ld,
    input  logic [7:0] f_in,
    input  logic [1:0] cc,
    output logic [7:0] f,
    output logic       carry,
    output logic       cond,
    output logic       pending,
    output logic       seq_err
);

    typedef enum logic {
        IDLE     = 1'b0,
        LOW_DONE = 1'b1
    } state_t;

    state_t state, state_nx;

    logic zero_lo, hc_lo, sh_lo;
    logic zero_lo_nx, hc_lo_nx, sh_lo_nx;
    logic flag_z, flag_n, flag_h, flag_c;
    logic flag_z_nx, flag_n_nx, flag_h_nx, flag_c_nx;
    logic seq_err_nx;

    logic commit;
    logic zero_eff, hc_eff, sh_eff;
    logic src_z, src_n, src_h, src_c;

    function automatic logic apply_sel(input logic [1:0] sel, input logic cur, input logic src);
        case (sel)
            2'b00:   apply_sel = cur;
            2'b01:   apply_sel = 1'b0;
            2'b10:   apply_sel = 1'b1;
            default: apply_sel = src;
        endcase
    endfunction

    // An h strobe with no captured low nibble behaves as if the low nibble were zero with no half-carry.
    assign zero_eff = (state == LOW_DONE) ? zero_lo : 1'b1;
    assign hc_eff   = (state == LOW_DONE) ? hc_lo   : 1'b0;
    assign sh_eff   = (state == LOW_DONE) ? sh_lo   : 1'b0;

    assign src_z = zero_eff & nib_zero;
    assign src_n = alu_ne;
    assign src_h = hc_eff;
    assign src_c = c_from_lo ? sh_eff : nib_cout;

    assign commit = alu_h & ~alu_l & ~f_ld;

    always_comb begin
        state_nx   = state;
        zero_lo_nx = zero_lo;
        hc_lo_nx   = hc_lo;
        sh_lo_nx   = sh_lo;
        flag_z_nx  = flag_z;
        flag_n_nx  = flag_n;
        flag_h_nx  = flag_h;
        flag_c_nx  = flag_c;
        seq_err_nx = seq_err;

        if (f_ld) begin
            flag_z_nx = f_in[7];
            flag_n_nx = f_in[6];
            flag_h_nx = f_in[5];
            flag_c_nx = f_in[4];
            state_nx  = IDLE;
        end else if (alu_l) begin
            zero_lo_nx = nib_zero;
            hc_lo_nx   = nib_cout;
            sh_lo_nx   = nib_cout;
            state_nx   = LOW_DONE;
            if (alu_h) begin
                seq_err_nx = 1'b1;
            end
        end else if (commit) begin
            flag_z_nx = apply_sel(z_sel, flag_z, src_z);
            flag_n_nx = apply_sel(n_sel, flag_n, src_n);
            flag_h_nx = apply_sel(h_sel, flag_h, src_h);
            flag_c_nx = apply_sel(c_sel, flag_c, src_c);
            state_nx  = IDLE;
            if (state == IDLE) begin
                seq_err_nx = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            zero_lo <= 1'b0;
            hc_lo   <= 1'b0;
            sh_lo   <= 1'b0;
            flag_z  <= 1'b0;
            flag_n  <= 1'b0;
            flag_h  <= 1'b0;
            flag_c  <= 1'b0;
            seq_err <= 1'b0;
        end else begin
            state   <= state_nx;
            zero_lo <= zero_lo_nx;
            hc_lo   <= hc_lo_nx;
            sh_lo   <= sh_lo_nx;
            flag_z  <= flag_z_nx;
            flag_n  <= flag_n_nx;
            flag_h  <= flag_h_nx;
            flag_c  <= flag_c_nx;
            seq_err <= seq_err_nx;
        end
    end

    assign f       = {flag_z, flag_n, flag_h, flag_c, 4'b0000};
    assign carry   = flag_c;
    assign pending = (state == LOW_DONE);

    always_comb begin
        case (cc)
            2'b00:   cond = ~flag_z;
            2'b01:   cond = flag_z;
            2'b10:   cond = ~flag_c;
            default: cond = flag_c;
        endcase
    end

endmodule

// File: tb/tb_alu_flag_unit.sv
// tb/tb_alu_flag_unit.sv - directed self-checking bench for alu_flag_unit
module tb_alu_flag_unit;

    logic       clk = 1'b0;
    logic       reset;
    logic       alu_l, alu_h, nib_zero, nib_cout, alu_ne, c_from_lo;
    logic [1:0] z_sel, n_sel, h_sel, c_sel;
    logic       f_ld;
    logic [7:0] f_in;
    logic [1:0] cc;
    logic [7:0] f;
    logic       carry, cond, pending, seq_err;

    int checks   = 0;
    int failures = 0;

    alu_flag_unit dut (
        .clk(clk), .reset(reset), .alu_l(alu_l), .alu_h(alu_h),
        .nib_zero(nib_zero), .nib_cout(nib_cout), .alu_ne(alu_ne), .c_from_lo(c_from_lo),
        .z_sel(z_sel), .n_sel(n_sel), .h_sel(h_sel), .c_sel(c_sel),
        .f_ld(f_ld), .f_in(f_in), .cc(cc),
        .f(f), .carry(carry), .cond(cond), .pending(pending), .seq_err(seq_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        reset = 0; alu_l = 0; alu_h = 0; nib_zero = 0; nib_cout = 0;
        alu_ne = 0; c_from_lo = 0; f_ld = 0; f_in = 8'h00;
        z_sel = 2'b00; n_sel = 2'b00; h_sel = 2'b00; c_sel = 2'b00;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        idle_inputs();
        cc = 2'b00;
        reset = 1;
        tick();
        reset = 0;
        tick();
        chk("reset_f", f, 8'h00);
        chk("reset_carry", {7'b0, carry}, 8'h00);
        chk("reset_pending", {7'b0, pending}, 8'h00);
        chk("reset_seq_err", {7'b0, seq_err}, 8'h00);

        // ADD 0x3A + 0xC6
        alu_l = 1; nib_zero = 1; nib_cout = 1;
        tick();
        chk("add_l_pending", {7'b0, pending}, 8'h01);
        chk("add_l_carry_old", {7'b0, carry}, 8'h00);
        alu_l = 0; alu_h = 1; nib_zero = 1; nib_cout = 1;
        z_sel = 2'b11; n_sel = 2'b01; h_sel = 2'b11; c_sel = 2'b11;
        tick();
        idle_inputs();
        chk("add_f", f, 8'hB0);
        chk("add_carry", {7'b0, carry}, 8'h01);
        chk("add_pending", {7'b0, pending}, 8'h00);
        cc = 2'b01; #1;
        chk("add_cond_z", {7'b0, cond}, 8'h01);
        cc = 2'b10; #1;
        chk("add_cond_nc", {7'b0, cond}, 8'h00);
        cc = 2'b00; #1;
        chk("add_cond_nz", {7'b0, cond}, 8'h00);
        cc = 2'b11; #1;
        chk("add_cond_c", {7'b0, cond}, 8'h01);

        // RRC 0x01 -> 0x80
        alu_l = 1; nib_zero = 1; nib_cout = 1;
        tick();
        alu_l = 0; alu_h = 1; nib_zero = 0; nib_cout = 0; c_from_lo = 1;
        z_sel = 2'b11; n_sel = 2'b01; h_sel = 2'b01; c_sel = 2'b11;
        tick();
        idle_inputs();
        chk("rrc_f", f, 8'h10);
        chk("rrc_carry", {7'b0, carry}, 8'h01);
        chk("rrc_seq_err", {7'b0, seq_err}, 8'h00);

        // POP AF
        f_ld = 1; f_in = 8'hFF;
        tick();
        chk("pop_ff", f, 8'hF0);
        f_in = 8'h0F;
        tick();
        idle_inputs();
        chk("pop_0f", f, 8'h00);

        // f_ld during LOW_DONE beats the commit
        alu_l = 1;
        tick();
        chk("fld_pre_pending", {7'b0, pending}, 8'h01);
        alu_l = 0; alu_h = 1; f_ld = 1; f_in = 8'hA5;
        z_sel = 2'b10; n_sel = 2'b10; h_sel = 2'b10; c_sel = 2'b10;
        tick();
        idle_inputs();
        chk("fld_override_f", f, 8'hA0);
        chk("fld_override_pending", {7'b0, pending}, 8'h00);
        chk("fld_override_seq_err", {7'b0, seq_err}, 8'h00);

        // reset mid-operation
        alu_l = 1; nib_zero = 0; nib_cout = 1;
        tick();
        alu_l = 0; reset = 1; alu_h = 1;
        z_sel = 2'b10; n_sel = 2'b10; h_sel = 2'b10; c_sel = 2'b10;
        tick();
        idle_inputs();
        chk("rst_mid_f", f, 8'h00);
        chk("rst_mid_pending", {7'b0, pending}, 8'h00);
        alu_h = 1; nib_zero = 1; nib_cout = 0;
        z_sel = 2'b11; n_sel = 2'b01; h_sel = 2'b11; c_sel = 2'b11;
        tick();
        idle_inputs();
        chk("orphan_h_f", f, 8'h80);
        chk("orphan_h_seq_err", {7'b0, seq_err}, 8'h01);

        // simultaneous l and h
        reset = 1;
        tick();
        reset = 0;
        tick();
        chk("rst_clears_seq_err", {7'b0, seq_err}, 8'h00);
        alu_l = 1; alu_h = 1; nib_zero = 1; nib_cout = 1;
        z_sel = 2'b10; n_sel = 2'b10; h_sel = 2'b10; c_sel = 2'b10;
        tick();
        idle_inputs();
        chk("both_seq_err", {7'b0, seq_err}, 8'h01);
        chk("both_pending", {7'b0, pending}, 8'h01);
        chk("both_f", f, 8'h00);
        alu_h = 1; nib_zero = 0; nib_cout = 0; alu_ne = 1;
        z_sel = 2'b11; n_sel = 2'b11; h_sel = 2'b11; c_sel = 2'b11;
        tick();
        idle_inputs();
        chk("both_follow_f", f, 8'h60);
        chk("both_follow_seq_err", {7'b0, seq_err}, 8'h01);
        chk("both_follow_pending", {7'b0, pending}, 8'h00);

        // no strobes: selects ignored, state held
        z_sel = 2'b10; n_sel = 2'b01; h_sel = 2'b01; c_sel = 2'b10;
        tick();
        tick();
        idle_inputs();
        chk("hold_f", f, 8'h60);

        // restart in LOW_DONE overwrites latches
        alu_l = 1; nib_zero = 0; nib_cout = 1;
        tick();
        nib_zero = 1; nib_cout = 0;
        tick();
        chk("restart_pending", {7'b0, pending}, 8'h01);
        alu_l = 0; alu_h = 1; nib_zero = 1; nib_cout = 1;
        z_sel = 2'b11; n_sel = 2'b00; h_sel = 2'b11; c_sel = 2'b00;
        tick();
        idle_inputs();
        chk("restart_f", f, 8'hC0);
        chk("restart_seq_err", {7'b0, seq_err}, 8'h01);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: observed=running expected=finished");
        $fatal(1);
    end

endmodule

// File: doc/alu_flag_unit.md
# alu_flag_unit

Flag register (F) and flag-update stage that sits directly downstream of the nibble-serial ALU. It consumes the per-nibble zero, carry and shift-out indications over the low-nibble (l) and high-nibble (h) cycles of an ALU operation. It commits Z/N/H/C into F at the end of the h cycle according to per-flag select codes from the sequencer. It feeds the stored carry back to the ALU and evaluates branch conditions for the sequencer.

## Interface
Parameters: none.
- `clk`  in  1  system clock; all state changes on rising edge
- `reset`  in  1  synchronous, active-high reset
- `alu_l`  in  1  ALU low-nibble cycle strobe
- `alu_h`  in  1  ALU high-nibble cycle strobe
- `nib_zero`  in  1  current nibble result is zero
- `nib_cout`  in  1  current nibble carry-out / shifted-out bit
- `alu_ne`  in  1  ALU operation is a subtract; source for N when selected
- `c_from_lo`  in  1  commit cycle: C(alu) takes the low-cycle `nib_cout` (right shifts) instead of the high-cycle one
- `z_sel`, `n_sel`, `h_sel`, `c_sel`  in  2 each  flag select, sampled on commit cycle: 00 keep, 01 clear, 10 set, 11 ALU source
- `f_ld`  in  1  direct load of F (POP AF)
- `f_in`  in  8  data for `f_ld`
- `cc`  in  2  condition code: 00 NZ, 01 Z, 10 NC, 11 C
- `f`  out  8  `{Z,N,H,C,4'b0000}`
- `carry`  out  1  stored C, to ALU carry-in
- `cond`  out  1  `cc` evaluated against stored F (combinational)
- `pending`  out  1  low nibble captured, awaiting h cycle
- `seq_err`  out  1  sticky sequencing-error flag

## Operation
- State machine, two states: IDLE, LOW_DONE. `pending` = (state == LOW_DONE).
- IDLE + `alu_l`: latch `zero_lo` = `nib_zero`, `hc_lo` = `nib_cout`, `sh_lo` = `nib_cout`; go to LOW_DONE.
- LOW_DONE + `alu_l`: restart. Overwrite the latches and stay in LOW_DONE.
- LOW_DONE + `alu_h`: commit; go to IDLE.
- IDLE + `alu_h` (no preceding l): commit with `zero_lo`=1 and `hc_lo`=0; set `seq_err`.
- `alu_l` and `alu_h` in the same cycle: treated as `alu_l` only; set `seq_err`.
- Commit, per flag with select 11:
  - Z = `zero_lo & nib_zero`
  - N = `alu_ne`
  - H = `hc_lo`
  - C = `c_from_lo ? sh_lo : nib_cout`
- Commit, other selects: 00 retains the flag, 01 forces 0, 10 forces 1.
- `f_ld`: F[7:4] ← `f_in[7:4]`; F[3:0] always 0.
  - Overrides any commit in the same cycle.
  - Aborts LOW_DONE → IDLE.
  - Does not touch `seq_err`.
- `cond`: NZ = !Z, Z = Z, NC = !C, C = C. Uses registered F only, never staged values.
- `seq_err` clears only on `reset`.

## Timing
- Reset values: `f` = 0x00, `carry` = 0, `pending` = 0, `seq_err` = 0, state IDLE, latches 0.
- Latency: F, `carry` and `cond` reflect a commit in the cycle after the h cycle. During the l and h cycles, `carry` still shows the old C, which is correct for ADC/SBC/RL/RR carry-in.
- `f_ld` is visible the next cycle.
- Cycles with neither strobe nor `f_ld` hold all state; LOW_DONE may persist indefinitely.
- `reset` asserted in LOW_DONE:
  - Discards the staged low-nibble data.
  - No commit occurs, even if `alu_h` is high that cycle.
- Select inputs are ignored outside the commit cycle.
- F[3:0] reads 0 at all times.

## Test plan
- ADD 0x3A+0xC6:
  - Stimulus: l cycle `nib_zero`=1, `nib_cout`=1; h cycle `nib_zero`=1, `nib_cout`=1; selects Z/H/C=11, N=01.
  - Response: `f`=0xB0 next cycle; `cond` with `cc`=01 is 1 and with `cc`=10 is 0.
- RRC 0x01 (result 0x80):
  - Stimulus: l cycle `nib_cout`=1, `nib_zero`=1; h cycle `nib_zero`=0, `nib_cout`=0; `c_from_lo`=1; Z/C=11, N/H=01.
  - Response: `f`=0x10, `carry`=1.
- POP AF with `f_in`=0xFF → `f`=0xF0. Then `f_ld` with `f_in`=0x0F → `f`=0x00.
- `f_ld` in LOW_DONE together with `alu_h` and all selects 10 → `f`=`f_in[7:4]`,0; `pending`=0; no commit.
- Reset mid-operation:
  - Stimulus: l cycle, then `reset` with `alu_h` and all selects 10.
  - Response: `f`=0x00, `pending`=0.
  - Follow-up: a fresh h cycle then sets `seq_err`=1 and commits with `zero_lo`=1.
- `alu_l` and `alu_h` together → `seq_err`=1, `pending`=1, F unchanged. A following h cycle commits normally; `seq_err` stays 1 until `reset`.
